// File: rtl/vx_dcr_boot_pkg.sv
// Shared definitions for the DCR boot controller: DCR map, FSM states, counter widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vx_dcr_boot_pkg;

  localparam int DCR_ADDR_W = 12;
  localparam int DCR_DATA_W = 32;
  localparam int MPM_W      = 8;
  localparam int CYCLES_W   = 44;

  // Startup register map
  localparam logic [DCR_ADDR_W-1:0] DCR_ADDR0     = 12'h001;
  localparam logic [DCR_ADDR_W-1:0] DCR_ADDR1     = 12'h002;
  localparam logic [DCR_ADDR_W-1:0] DCR_ARG0      = 12'h003;
  localparam logic [DCR_ADDR_W-1:0] DCR_ARG1      = 12'h004;
  localparam logic [DCR_ADDR_W-1:0] DCR_MPM_CLASS = 12'h005;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_BUSY_WAIT,
    ST_RUN,
    ST_DONE
  } state_e;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vx_dcr_boot_ctrl_if.sv
// Host/core-facing signal bundle of the DCR boot controller.
// Latency: n/a (wires only).
// Backpressure: none; DCR writes are fire-and-forget strobes.
interface vx_dcr_boot_ctrl_if;
  import vx_dcr_boot_pkg::*;

  logic                  dcr_wr_valid;
  logic [DCR_ADDR_W-1:0] dcr_wr_addr;
  logic [DCR_DATA_W-1:0] dcr_wr_data;
  logic                  start;
  logic                  vx_busy;
  logic                  vx_reset;
  logic [63:0]           startup_addr;
  logic [63:0]           startup_arg;
  logic [MPM_W-1:0]      mpm_class;
  logic                  running;
  logic                  done;
  logic                  timeout;
  logic                  dcr_err;
  logic [CYCLES_W-1:0]   cycles;

  // Host shim plus core busy source
  modport master (
    output dcr_wr_valid, dcr_wr_addr, dcr_wr_data, start, vx_busy,
    input  vx_reset, startup_addr, startup_arg, mpm_class,
    input  running, done, timeout, dcr_err, cycles
  );

  // Boot controller
  modport slave (
    input  dcr_wr_valid, dcr_wr_addr, dcr_wr_data, start, vx_busy,
    output vx_reset, startup_addr, startup_arg, mpm_class,
    output running, done, timeout, dcr_err, cycles
  );

endinterface

// File: rtl/vx_dcr_bank.sv
// Startup DCR bank: decodes host writes into five registers, flags illegal writes.
// Latency: a write at edge t is visible on the outputs after t.
// Backpressure: none; writes outside IDLE or to unknown addresses are dropped and flagged.
module vx_dcr_bank
  import vx_dcr_boot_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  idle_i,
  input  logic                  wr_vld_i,
  input  logic [DCR_ADDR_W-1:0] wr_addr_i,
  input  logic [DCR_DATA_W-1:0] wr_data_i,
  output logic [63:0]           startup_addr_o,
  output logic [63:0]           startup_arg_o,
  output logic [MPM_W-1:0]      mpm_class_o,
  output logic                  dcr_err_o
);

  logic [DCR_DATA_W-1:0] addr0_q, addr1_q, arg0_q, arg1_q;
  logic [MPM_W-1:0]      mpm_q;
  logic                  err_q;

  // Commit legal writes while IDLE; anything else sets the sticky error flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr0_q <= '0;
      addr1_q <= '0;
      arg0_q  <= '0;
      arg1_q  <= '0;
      mpm_q   <= '0;
      err_q   <= 1'b0;
    end else if (wr_vld_i) begin
      if (!idle_i) begin
        err_q <= 1'b1;
      end else begin
        unique case (wr_addr_i)
          DCR_ADDR0:     addr0_q <= wr_data_i;
          DCR_ADDR1:     addr1_q <= wr_data_i;
          DCR_ARG0:      arg0_q  <= wr_data_i;
          DCR_ARG1:      arg1_q  <= wr_data_i;
          DCR_MPM_CLASS: mpm_q   <= wr_data_i[MPM_W-1:0];
          default:       err_q   <= 1'b1;
        endcase
      end
    end
  end

  assign startup_addr_o = {addr1_q, addr0_q};
  assign startup_arg_o  = {arg1_q, arg0_q};
  assign mpm_class_o    = mpm_q;
  assign dcr_err_o      = err_q;

endmodule

// File: rtl/vx_dcr_boot_ctrl.sv
// Core boot sequencer: holds vx_reset for RESET_DELAY cycles, waits for busy, times the kernel.
// Latency: running after 1 edge from start, vx_reset drops RESET_DELAY edges after start, done 1 edge after busy falls.
// Backpressure: start is only sampled in IDLE; starts arriving elsewhere are dropped, not queued.
module vx_dcr_boot_ctrl
  import vx_dcr_boot_pkg::*;
#(
  parameter int RESET_DELAY  = 8,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic resetn,
  vx_dcr_boot_ctrl_if.slave bus
);

  // One counter serves both the reset hold and the busy wait, sized for the longer.
  localparam int DLY_W = cnt_w(RESET_DELAY);
  localparam int TMO_W = cnt_w(BUSY_TIMEOUT);
  localparam int CNT_W = (DLY_W > TMO_W) ? DLY_W : TMO_W;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RESET_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [CYCLES_W-1:0] cycles_q;
  logic [CYCLES_W-1:0] cycles_d;
  logic                vx_reset_q;
  logic                running_q;
  logic                done_q;
  logic                timeout_q;

  // Kernel cycle count saturates instead of wrapping.
  assign cycles_d = (&cycles_q) ? cycles_q : cycles_q + CYCLES_W'(1);
  assign cnt_d    = cnt_q + CNT_W'(1);

  // Boot FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cycles_q   <= '0;
      vx_reset_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            cycles_q   <= '0;
            timeout_q  <= 1'b0;
            running_q  <= 1'b1;
            vx_reset_q <= 1'b1;
          end
        end
        ST_RESET: begin
          if (cnt_q == DLY_LAST) begin
            state_q    <= ST_BUSY_WAIT;
            cnt_q      <= '0;
            vx_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_BUSY_WAIT: begin
          cycles_q <= cycles_d;
          // A busy seen on the last wait cycle still counts as a launch.
          if (bus.vx_busy) begin
            state_q <= ST_RUN;
          end else if (cnt_q == TMO_LAST) begin
            state_q    <= ST_DONE;
            timeout_q  <= 1'b1;
            vx_reset_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RUN: begin
          cycles_q <= cycles_d;
          if (!bus.vx_busy) begin
            state_q    <= ST_DONE;
            vx_reset_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          vx_reset_q <= 1'b1;
          running_q  <= 1'b0;
        end
      endcase
    end
  end

  vx_dcr_bank u_bank (
    .clk            (clk),
    .resetn         (resetn),
    .idle_i         (state_q == ST_IDLE),
    .wr_vld_i       (bus.dcr_wr_valid),
    .wr_addr_i      (bus.dcr_wr_addr),
    .wr_data_i      (bus.dcr_wr_data),
    .startup_addr_o (bus.startup_addr),
    .startup_arg_o  (bus.startup_arg),
    .mpm_class_o    (bus.mpm_class),
    .dcr_err_o      (bus.dcr_err)
  );

  assign bus.vx_reset = vx_reset_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;
  assign bus.cycles   = cycles_q;

endmodule
